// File: rtl/clk_div_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor.
// Sizing helpers are functions so they follow the top-level parameters.
package clk_div_monitor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    // Wide enough for the largest legal LOCK_COUNT (15).
    localparam int MATCH_W = 4;

    localparam int DEFAULT_CNT_W = 8;

    // Saturation value of the period counter for a given counter width.
    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    localparam int unsigned DEFAULT_CNT_MAX = cnt_max(DEFAULT_CNT_W);

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clkin and emits registered
// single-cycle rise/fall strobes from the synchronised copy.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   last;

    assign last = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_reg   <= '0;
            prev_reg   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], async_in};
            prev_reg   <= last;
            rise_pulse <= last & ~prev_reg;
            fall_pulse <= ~last & prev_reg;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the rise-to-rise period of an observed divided clock, tracks lock
// against the programmed divisor and flags loss of clock.
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] expected_div,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

    mon_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [MATCH_W-1:0] match_run_reg;
    logic               is_match;
    logic [MATCH_W-1:0] match_run_next;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clkin     (clkin),
        .rst       (rst),
        .async_in  (div_clk),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    // A zero divisor is treated as "unprogrammed" and can never match.
    assign is_match       = (cnt_reg == expected_div) && (expected_div != '0);
    assign match_run_next = (match_run_reg == LOCK_TGT) ? LOCK_TGT
                                                        : match_run_reg + MATCH_W'(1);

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            match_run_reg <= '0;
            period        <= '0;
            period_valid  <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    locked  <= 1'b0;
                    if (rise_pulse) begin
                        state_reg <= TRACK;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                TRACK: begin
                    // A rise in the saturation cycle still counts as a measurement.
                    if (rise_pulse) begin
                        period       <= cnt_reg;
                        period_valid <= 1'b1;
                        cnt_reg      <= CNT_W'(1);
                        if (is_match) begin
                            match_run_reg <= match_run_next;
                            if (match_run_next == LOCK_TGT) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_run_reg <= '0;
                            locked        <= 1'b0;
                        end
                    end else if (cnt_reg == CNT_MAX) begin
                        timeout       <= 1'b1;
                        locked        <= 1'b0;
                        match_run_reg <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: measurements are scoreboarded per rise,
// timing-sensitive behaviour is checked inline.
module tb_clk_div_monitor;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       div_clk = 1'b0;
    logic [7:0] expected_div = 8'd0;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    typedef struct {
        logic [7:0] p;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    clk_div_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .LOCK_COUNT (4)
    ) dut (
        .clkin       (clkin),
        .rst         (rst),
        .div_clk     (div_clk),
        .expected_div(expected_div),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial forever #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rise"},    rise_pulse,   0);
        check({tag, ".fall"},    fall_pulse,   0);
        check({tag, ".period"},  period,       0);
        check({tag, ".pvalid"},  period_valid, 0);
        check({tag, ".locked"},  locked,       0);
        check({tag, ".timeout"}, timeout,      0);
    endtask

    // One div_clk period starting with a rise. If push is set, the entry
    // describes the measurement that this rise completes.
    task automatic cyc(input int hi, input int lo, input bit push,
                       input logic [7:0] exp_p, input logic exp_l);
        exp_t e;
        if (push) begin
            e.p = exp_p;
            e.l = exp_l;
            q.push_back(e);
        end
        div_clk = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            step();
            check("rise_latency", rise_pulse, (i == 3));
        end
        div_clk = 1'b0;
        for (int i = 1; i <= lo; i++) begin
            step();
            check("fall_latency", fall_pulse, (i == 3));
        end
    endtask

    // Scoreboard: every period_valid must match the oldest pushed expectation.
    always begin
        exp_t e;
        @(posedge clkin);
        #1;
        if (period_valid) begin
            check("pvalid_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                $display("txn period=%0d locked=%0d exp_period=%0d exp_locked=%0d",
                         period, locked, e.p, e.l);
                check("sb_period", period, e.p);
                check("sb_locked", locked, e.l);
            end
        end
    end

    initial begin
        int   n;
        bit   seen;
        exp_t e;

        // Reset with div_clk toggling, then release with div_clk low.
        rst = 1'b1;
        step(); div_clk = 1'b1;
        step(); div_clk = 1'b0;
        step();
        rst = 1'b0;
        repeat (5) step();
        check_idle("reset");

        // Lock acquisition at period 8, then a single period of 10.
        expected_div = 8'd8;
        cyc(4, 4, 0, 0, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(5, 5, 1, 8, 1);
        cyc(4, 4, 1, 10, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 1);

        // Loss of clock: one more rise, then div_clk stuck high.
        e.p = 8'd8;
        e.l = 1'b1;
        q.push_back(e);
        div_clk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = period_valid;
        end
        check("lost_pvalid_seen", seen, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            step();
            n++;
            seen = timeout;
        end
        check("timeout_delay", n, 255);
        check("timeout_locked", locked, 0);
        check("timeout_period", period, 8);
        step();
        check("timeout_oneshot", timeout, 0);

        // Restart: first rise gives no measurement, the second does.
        div_clk = 1'b0;
        repeat (4) step();
        cyc(4, 4, 0, 0, 0);
        cyc(4, 4, 1, 8, 0);

        // expected_div = 0 never matches but still reports the period.
        expected_div = 8'd0;
        for (int i = 0; i < 5; i++) cyc(4, 4, 1, 8, 0);

        // Re-lock at 8, then retarget to 6 while locked.
        expected_div = 8'd8;
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 0);
        cyc(4, 4, 1, 8, 1);
        expected_div = 8'd6;
        cyc(4, 4, 1, 8, 0);

        // Reset coinciding with a rise strobe while tracking.
        repeat (40) step();
        check("pre_midrst_queue", q.size(), 0);
        expected_div = 8'd8;
        div_clk = 1'b1;
        repeat (3) step();
        check("midrst_rise", rise_pulse, 1);
        rst = 1'b1;
        step();
        check_idle("midrst");
        rst = 1'b0;
        div_clk = 1'b0;
        repeat (6) step();
        check_idle("post_midrst");

        repeat (10) step();
        check("final_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
